// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer.
// A single full-adder slice is walked over WIDTH-bit operands, LSB first,
// one bit per clock. Operands enter on a valid/ready start handshake and the
// sum plus final carry leave on a valid/ready done handshake.
//
// Timeline for one operation (E0 = accept edge):
//   E0            : operands latched, IDLE -> ADD
//   E1 .. E_WIDTH : one bit per edge; E_WIDTH also moves ADD -> DONE
//   after E_WIDTH : done_valid high, result held until done_ready
//   handshake edge: DONE -> IDLE, start_ready high again next cycle
// Minimum back-to-back period is therefore WIDTH+2 cycles.

module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,

    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             done_valid,
    input  logic             done_ready,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen on the edge that processes the final (MSB) bit.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    // Full-adder slice on the current LSBs and the next sum shift value.
    logic               bit_sum;
    logic               carry_nxt;
    logic [WIDTH-1:0]   sum_nxt;

    // Single full-adder datapath; the new sum bit enters at the MSB so that
    // after WIDTH shifts the first bit computed sits at bit 0.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update so
        // no path leaves it unassigned, which would infer a latch.
        bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_nxt   = sum_sh >> 1;
        sum_nxt[WIDTH-1] = bit_sum;
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the operand/sum shift registers are ordinary flops, not a
            // memory array, so clearing them on reset costs nothing and makes
            // an aborted operation leave no trace.
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_out     <= '0;
            cout_out    <= 1'b0;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout: every right-hand side
            // reads the pre-edge value, so the shift/carry updates below all
            // see the same bit position regardless of statement order.
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_sh        <= a_in;
                        b_sh        <= b_in;
                        carry       <= cin_in;
                        sum_sh      <= '0;
                        cnt         <= '0;
                        state       <= ADD;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + CNT_ONE;
                    if (cnt == LAST_CNT) begin
                        // Publish the completed result straight from the
                        // last slice so it is valid the cycle DONE begins.
                        state      <= DONE;
                        done_valid <= 1'b1;
                        sum_out    <= sum_nxt;
                        cout_out   <= carry_nxt;
                    end
                end

                DONE: begin
                    // sum_out/cout_out are not touched here, so they stay
                    // constant under backpressure and after leaving DONE.
                    if (done_valid && done_ready) begin
                        state       <= IDLE;
                        done_valid  <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    done_valid  <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
